cycle_sequencer: RTL and testbench
==================================

Name: cycle_sequencer

Overview:
- Generates the machine-cycle (M1..M5) and T-state (T1..T6) one-hot timing strobes for the CPU core.
- Consumes the internal reset `nreset` produced by the reset block. Feeds M1/T1/T2 back to it, so the reset block can hold CLRPC until the first M1/T2 after reset.
- Inserts wait states on `nwait`, handles bus request/acknowledge, and supports halt.

Parameters:
- MAX_T, 6, highest T-state index; cycle length is clamped to 3..MAX_T.
- MAX_M, 5, highest M-cycle index; the cycle after M{MAX_M} is always M1.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- nreset  input  1  internal reset; asynchronous assert, active-low.
- tlen  input  3  length in T-states of the current M cycle; sampled at T1.
- setM1  input  1  decoder request: the next M cycle is M1 (instruction end).
- halt  input  1  CPU halted: M1 repeats with no PC advance (PC handled elsewhere).
- nwait  input  1  active-low WAIT pin, already synchronised.
- busrq  input  1  bus request, already synchronised.
- M  output  MAX_M  one-hot machine-cycle strobes, bit0 = M1.
- T  output  MAX_T  one-hot T-state strobes, bit0 = T1.
- twait  output  1  high during an inserted wait state.
- busack  output  1  bus granted; core drives nothing.
- cycle_end  output  1  combinational, high in the final T-state of the current M cycle (not in wait).

Behaviour:
- Reset (nreset=0, asynchronous): M=...00001, T=...00001, twait=0, busack=0, latched length=4. The first rising edge after release moves M1/T1 to M1/T2.
- Length latch: `tlen` is captured on the edge that leaves T1 and held for the rest of the cycle.
  - T1 itself always counts as part of the cycle.
  - Values below 3 are clamped to 3; values above MAX_T are clamped to MAX_T.
- T advance: each clock moves T one-hot left by one, except in the wait, cycle-end and bus-grant cases below.
- Wait:
  - If nwait=0 is sampled in T2 (or in a wait state), the next state is a wait state: T2 is held and twait=1.
  - When nwait=1 is sampled in a wait state, the sequencer proceeds to T3 with twait=0.
  - Wait can be inserted only from T2. nwait has no effect in any other T-state.
- Cycle end: when T equals the latched length, cycle_end=1. The next edge sets T=T1 and selects the next M by priority:
  1. busrq=1: enter grant. busack=1, T and M strobes are all 0, and the pending next-M choice is stored.
  2. setM1=1, halt=1, or M is at MAX_M: next M is M1.
  3. Otherwise: M shifts left by one.
- Grant:
  - While busrq=1, remain in grant.
  - The first edge with busrq=0 clears busack and resumes at the stored M with T1.
  - busrq is ignored at any time other than cycle end.
- Simultaneous setM1 and busrq at cycle end: grant is taken first; resume is at M1.
- Wait versus busrq: busrq is not honoured during a wait state; it is sampled only at cycle end.
- Reset mid-cycle, during wait or during grant: immediate return to the reset values; busack drops asynchronously.
- Invariant: outside grant, M and T are each exactly one-hot. In grant both are zero.

Decomposition:
- Shared package `core_pkg`:
  - constants MAX_T and MAX_M;
  - the sequencer state enum {SEQ_RUN, SEQ_WAIT, SEQ_GRANT};
  - the clamp function for tlen.
- One sub-module, `tstate_counter`:
  - owns the T one-hot, the length latch, the wait hold and cycle_end;
  - the top level owns M selection and the grant FSM.

Test Plan:
- Reset release with tlen=4, setM1=1 held → M1 with T1,T2,T3,T4, then M1/T1 again; cycle_end high only in T4.
- tlen=3, setM1=0 for 6 cycles → M1,M2,M3,M4,M5,M1 each 3 clocks; wrap after M5.
- nwait=0 for 2 clocks starting in M1/T2 → T2 lasts 3 clocks, twait=1 on the last 2, then T3 and T4; the cycle is 6 clocks total.
- busrq=1 asserted in M2/T2, dropped 4 clocks after cycle end with setM1=1 → busack=1 for exactly 4 clocks starting after M2's last T; resume at M1/T1.
- halt=1 with setM1=0, tlen=4 → M1 repeats indefinitely; M2 never asserted.
- nreset pulsed low during a wait state in M3/T2 → immediately M1/T1, twait=0, busack=0; the next edge after release gives M1/T2.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants, sequencer state encoding and the M-cycle length clamp for the CPU core.
package core_pkg;

  localparam int unsigned MAX_T = 6;
  localparam int unsigned MAX_M = 5;
  localparam int unsigned TLEN_W = 3;

  typedef enum logic [1:0] {
    SEQ_RUN   = 2'd0,
    SEQ_WAIT  = 2'd1,
    SEQ_GRANT = 2'd2
  } seq_state_t;

  // Limit a requested cycle length to 3..MAX_T T-states.
  function automatic logic [TLEN_W-1:0] clamp_tlen(input logic [TLEN_W-1:0] raw);
    if (raw < TLEN_W'(3)) return TLEN_W'(3);
    if (32'(raw) > MAX_T) return TLEN_W'(MAX_T);
    return raw;
  endfunction

endpackage

// File: rtl/cycle_sequencer_tstate_counter.sv
// T-state one-hot, latched cycle length, T2 wait hold and cycle-end detection.
module tstate_counter
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic [TLEN_W-1:0] tlen,
  input  logic              nwait,
  input  logic              busrq,
  input  logic              grant,
  output logic [MAX_T-1:0]  t,
  output logic              twait,
  output logic              cycle_end
);

  seq_state_t        state, state_next;
  logic [MAX_T-1:0]  t_next;
  logic [TLEN_W-1:0] len, len_next;
  logic              end_hit;

  // Final T-state of the cycle; never true in wait (T2 < 3) or grant (T all zero).
  assign end_hit = (state == SEQ_RUN) && !grant &&
                   (t == (MAX_T'(1) << (len - TLEN_W'(1))));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= SEQ_RUN;
      t     <= MAX_T'(1);
      len   <= TLEN_W'(4);
    end else begin
      state <= state_next;
      t     <= t_next;
      len   <= len_next;
    end
  end

  always_comb begin
    state_next = state;
    t_next     = t;
    len_next   = len;
    if (t[0]) len_next = clamp_tlen(tlen);
    if (grant) begin
      t_next = busrq ? '0 : MAX_T'(1);
    end else if (end_hit) begin
      t_next = busrq ? '0 : MAX_T'(1);
    end else if (state == SEQ_WAIT) begin
      if (nwait) begin
        state_next = SEQ_RUN;
        t_next     = MAX_T'(4);
      end
    end else if (t[1] && !nwait) begin
      state_next = SEQ_WAIT;
    end else begin
      t_next = t << 1;
    end
  end

  always_comb begin
    twait     = (state == SEQ_WAIT);
    cycle_end = end_hit;
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Machine-cycle sequencer: M-cycle selection and bus-grant FSM around the T-state counter.
module cycle_sequencer
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic [TLEN_W-1:0] tlen,
  input  logic              setM1,
  input  logic              halt,
  input  logic              nwait,
  input  logic              busrq,
  output logic [MAX_M-1:0]  M,
  output logic [MAX_T-1:0]  T,
  output logic              twait,
  output logic              busack,
  output logic              cycle_end
);

  seq_state_t       state, state_next;
  logic [MAX_M-1:0] m, m_next;
  logic [MAX_M-1:0] m_saved, m_saved_next;
  logic [MAX_M-1:0] m_choice;
  logic             grant;

  tstate_counter u_tstate (
    .clk       (clk),
    .nreset    (nreset),
    .tlen      (tlen),
    .nwait     (nwait),
    .busrq     (busrq),
    .grant     (grant),
    .t         (T),
    .twait     (twait),
    .cycle_end (cycle_end)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= SEQ_RUN;
      m       <= MAX_M'(1);
      m_saved <= MAX_M'(1);
    end else begin
      state   <= state_next;
      m       <= m_next;
      m_saved <= m_saved_next;
    end
  end

  // Next M after the current one ends: M1 on instruction end, halt or wrap.
  assign m_choice = (setM1 || halt || m[MAX_M-1]) ? MAX_M'(1) : (m << 1);

  always_comb begin
    state_next   = state;
    m_next       = m;
    m_saved_next = m_saved;
    case (state)
      SEQ_RUN: begin
        if (cycle_end) begin
          if (busrq) begin
            state_next   = SEQ_GRANT;
            m_next       = '0;
            m_saved_next = m_choice;
          end else begin
            m_next = m_choice;
          end
        end
      end
      SEQ_GRANT: begin
        if (!busrq) begin
          state_next = SEQ_RUN;
          m_next     = m_saved;
        end
      end
      default: state_next = SEQ_RUN;
    endcase
  end

  always_comb begin
    grant  = (state == SEQ_GRANT);
    busack = grant;
    M      = m;
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed and randomized checks of cycle_sequencer against an index-level behavioural model.
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       nreset;
  logic [2:0] tlen;
  logic       setm1, halt, nwait, busrq;
  logic [4:0] mcyc;
  logic [5:0] tst;
  logic       twait, busack, cycle_end;

  int errs = 0;
  int checks = 0;

  // Model state as plain indices: m_idx/t_idx 1-based, 0 while granted.
  int m_idx, t_idx, len, saved;
  bit waiting, granted;
  bit m2_seen;

  cycle_sequencer dut (
    .clk       (clk),
    .nreset    (nreset),
    .tlen      (tlen),
    .setM1     (setm1),
    .halt      (halt),
    .nwait     (nwait),
    .busrq     (busrq),
    .M         (mcyc),
    .T         (tst),
    .twait     (twait),
    .busack    (busack),
    .cycle_end (cycle_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 3) return 3;
    if (v > 6) return 6;
    return v;
  endfunction

  task automatic model_reset();
    m_idx = 1; t_idx = 1; len = 4; saved = 1; waiting = 0; granted = 0;
  endtask

  function automatic bit model_end();
    return !granted && !waiting && (t_idx == len);
  endfunction

  task automatic model_step();
    int nm;
    if (granted) begin
      if (!busrq) begin
        granted = 0; m_idx = saved; t_idx = 1;
      end
    end else if (model_end()) begin
      nm = (setm1 || halt || m_idx == 5) ? 1 : m_idx + 1;
      if (busrq) begin
        granted = 1; saved = nm; m_idx = 0; t_idx = 0;
      end else begin
        m_idx = nm; t_idx = 1;
      end
    end else if (waiting) begin
      if (nwait) begin
        waiting = 0; t_idx = 3;
      end
    end else if (t_idx == 2 && !nwait) begin
      waiting = 1;
    end else begin
      if (t_idx == 1) len = clamp(int'(tlen));
      t_idx++;
    end
  endtask

  task automatic compare_all();
    int em, et;
    em = (m_idx == 0) ? 0 : (1 << (m_idx - 1));
    et = (t_idx == 0) ? 0 : (1 << (t_idx - 1));
    check("M", int'(mcyc), em);
    check("T", int'(tst), et);
    check("twait", int'(twait), int'(waiting));
    check("busack", int'(busack), int'(granted));
    check("cycle_end", int'(cycle_end), int'(model_end()));
    if (mcyc[1]) m2_seen = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    nreset = 1'b0; tlen = 3'd4; setm1 = 1'b1; halt = 1'b0; nwait = 1'b1; busrq = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    check("reset_M_lit", int'(mcyc), 1);
    check("reset_T_lit", int'(tst), 1);
    nreset = 1'b1;

    // Reset release, 4-state M1 repeating
    cyc(); check("rel_T2_lit", int'(tst), 2);
    cyc(); cyc();
    check("t4_lit", int'(tst), 8);
    check("t4_end_lit", int'(cycle_end), 1);
    cyc();
    check("m1_again_lit", int'(mcyc), 1);
    check("t1_again_lit", int'(tst), 1);

    // 3-state cycles walk M1..M5 and wrap
    setm1 = 1'b0; tlen = 3'd3;
    repeat (12) cyc();
    check("m5_lit", int'(mcyc), 16);
    repeat (3) cyc();
    check("wrap_m1_lit", int'(mcyc), 1);

    // Two wait states in M1/T2
    tlen = 3'd4; setm1 = 1'b1;
    cyc();
    nwait = 1'b0;
    cyc(); cyc();
    check("wait_twait_lit", int'(twait), 1);
    check("wait_T2_lit", int'(tst), 2);
    nwait = 1'b1;
    cyc(); check("wait_T3_lit", int'(tst), 4);
    cyc(); cyc();
    check("wait_done_lit", int'(tst), 1);

    // Bus grant entered at end of M2, resume at M1
    setm1 = 1'b0; tlen = 3'd3;
    repeat (3) cyc();
    cyc();
    busrq = 1'b1; setm1 = 1'b1;
    cyc();
    cyc();
    check("grant_busack_lit", int'(busack), 1);
    check("grant_M_lit", int'(mcyc), 0);
    repeat (3) cyc();
    busrq = 1'b0;
    cyc();
    check("resume_M1_lit", int'(mcyc), 1);
    check("resume_T1_lit", int'(tst), 1);
    check("resume_busack_lit", int'(busack), 0);

    // Halt keeps M1 repeating
    setm1 = 1'b0; halt = 1'b1; tlen = 3'd4; m2_seen = 0;
    repeat (20) cyc();
    check("halt_no_m2", int'(m2_seen), 0);

    // Reset pulse during a wait in M3/T2
    halt = 1'b0; tlen = 3'd3;
    repeat (6) cyc();
    cyc();
    nwait = 1'b0;
    cyc();
    check("m3_wait_lit", int'(mcyc), 4);
    check("m3_twait_lit", int'(twait), 1);
    #2 nreset = 1'b0;
    #1;
    model_reset();
    check("async_M_lit", int'(mcyc), 1);
    check("async_T_lit", int'(tst), 1);
    check("async_twait_lit", int'(twait), 0);
    check("async_busack_lit", int'(busack), 0);
    @(negedge clk);
    nreset = 1'b1; nwait = 1'b1;
    cyc();
    check("post_rst_T2_lit", int'(tst), 2);
    check("post_rst_M1_lit", int'(mcyc), 1);

    // Randomized run, including resets during wait/grant
    for (int i = 0; i < 3000; i++) begin
      tlen  = 3'($urandom_range(0, 7));
      setm1 = ($urandom_range(0, 9) < 4);
      halt  = ($urandom_range(0, 19) == 0);
      nwait = ($urandom_range(0, 9) >= 3);
      busrq = granted ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 nreset = 1'b0;
        #1;
        model_reset();
        compare_all();
        nreset = 1'b1;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
